keypad_scanner: RTL

Scans a 4x4 active-low hex keypad, debounces it, and captures keys into a 32-bit entry register the RISC-V core reads as input. This is the input-side counterpart of the seven-segment display path: the display shows the processor's 32-bit result one hex digit at a time, and this block assembles a 32-bit operand one hex digit per keypress. Each new key raises an interrupt request to the core, and the request is held until the core acknowledges it.

---
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/keypad_scanner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad scanner, the keypad pins and the core.
// The scanner takes the slave side; whoever drives the keypad and acknowledges irqs takes master.
interface keypad_scanner_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        entry_clear;
    logic        irq_ack;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [31:0] entry;
    logic        irq;
    logic        overrun;
    logic [1:0]  state_dbg;

    // Handshake: key_valid is a one-cycle pulse with no ready; irq is a level held until
    // irq_ack is seen high on a clock edge, and an acceptance on that same edge wins.
    modport master (
        output row_in, entry_clear, irq_ack,
        input  col_out, key_valid, key_code, key_held, entry, irq, overrun, state_dbg
    );

    modport slave (
        input  row_in, entry_clear, irq_ack,
        output col_out, key_valid, key_code, key_held, entry, irq, overrun, state_dbg
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce, hex entry shift register and held irq.
// state_dbg exposes the scan FSM: 0 = SCAN, 1 = DEBOUNCE, 2 = PRESSED.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.slave  bus
);
    localparam int DW_W  = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_TARGET  = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [3:0]       r_sync1, r_sync2;
    logic [DW_W-1:0]  r_dwell;
    logic [1:0]       r_col;
    logic [3:0]       r_latched;
    logic [CNT_W-1:0] r_match, r_release;
    logic [CNT_W-1:0] w_match_next, w_release_next;
    logic             w_sample, w_advance, w_accept, w_release_done, w_latch;
    logic [3:0]       w_rs;
    logic [3:0]       w_code;
    logic             r_key_valid, r_key_held, r_irq, r_overrun;
    logic [3:0]       r_key_code;
    logic [31:0]      r_entry;

    // Several closed keys in one column resolve to the lowest row index.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        lowest_low = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) lowest_low = 2'(i);
        end
    endfunction

    assign w_rs     = r_sync2;
    assign w_sample = (r_dwell == DWELL_LAST);
    assign w_code   = {lowest_low(r_latched), r_col};

    always_comb begin
        w_state_next   = r_state;
        w_match_next   = r_match;
        w_release_next = r_release;
        w_advance      = 1'b0;
        w_accept       = 1'b0;
        w_release_done = 1'b0;
        w_latch        = 1'b0;
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (w_rs == 4'hF) begin
                        w_advance = 1'b1;
                    end else begin
                        w_latch      = 1'b1;
                        w_match_next = CNT_W'(1);
                        w_state_next = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (w_rs == r_latched) begin
                        w_match_next = r_match + 1'b1;
                        if (w_match_next == DB_TARGET) begin
                            w_accept       = 1'b1;
                            w_match_next   = '0;
                            w_release_next = '0;
                            w_state_next   = PRESSED;
                        end
                    end else begin
                        w_advance    = 1'b1;
                        w_match_next = '0;
                        w_state_next = SCAN;
                    end
                end
                PRESSED: begin
                    // Any closed sample restarts the release run, so a held key never repeats.
                    if (w_rs == 4'hF) begin
                        w_release_next = r_release + 1'b1;
                        if (w_release_next == DB_TARGET) begin
                            w_release_done = 1'b1;
                            w_advance      = 1'b1;
                            w_release_next = '0;
                            w_state_next   = SCAN;
                        end
                    end else begin
                        w_release_next = '0;
                    end
                end
                default: w_state_next = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= SCAN;
            r_match   <= '0;
            r_release <= '0;
            r_dwell   <= '0;
            r_col     <= 2'd0;
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_latched <= 4'hF;
        end else begin
            r_state   <= w_state_next;
            r_match   <= w_match_next;
            r_release <= w_release_next;
            r_dwell   <= w_sample ? '0 : r_dwell + 1'b1;
            r_sync1   <= bus.row_in;
            r_sync2   <= r_sync1;
            if (w_advance) r_col <= r_col + 2'd1;
            if (w_latch) r_latched <= w_rs;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_key_held  <= 1'b0;
            r_entry     <= 32'h0;
            r_irq       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= w_code;
                r_key_held <= 1'b1;
            end else if (w_release_done) begin
                r_key_held <= 1'b0;
            end
            // A clear that lands with an acceptance keeps only the new digit.
            if (w_accept) begin
                r_entry <= bus.entry_clear ? {28'h0, w_code} : {r_entry[27:0], w_code};
            end else if (bus.entry_clear) begin
                r_entry <= 32'h0;
            end
            if (w_accept) r_irq <= 1'b1;
            else if (bus.irq_ack) r_irq <= 1'b0;
            if (w_accept && r_irq) r_overrun <= 1'b1;
            else if (bus.irq_ack) r_overrun <= 1'b0;
        end
    end

    assign bus.col_out   = ~(4'b0001 << r_col);
    assign bus.key_valid = r_key_valid;
    assign bus.key_code  = r_key_code;
    assign bus.key_held  = r_key_held;
    assign bus.entry     = r_entry;
    assign bus.irq       = r_irq;
    assign bus.overrun   = r_overrun;
    assign bus.state_dbg = r_state;
endmodule
